// File: rtl/pronoc_pkg.sv
// Shared types and helpers for the straight output-port arbiter and its credit counters.
package pronoc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } ss_arb_state_t;

  // Counter must hold every value from 0 to depth inclusive.
  function automatic int crd_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ss_ovc_credit_counter.sv
// Per-VC downstream credit counter: resets full, decrements on grant, increments on credit return.
module ss_ovc_credit_counter
  import pronoc_pkg::*;
#(
  parameter int B = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dec,
  input  logic inc,
  output logic avb,
  output logic ovf
);

  localparam int W = crd_cnt_w(B);
  localparam logic [W-1:0] FULL = W'(B);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= FULL;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else if (inc && !dec && cnt != FULL) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign avb = (cnt != '0);
  // A return that would push past the buffer depth is dropped and flagged.
  assign ovf = inc && !dec && (cnt == FULL);

endmodule

// File: rtl/ss_oport_arbiter.sv
// Wormhole arbiter for one straight output port with per-VC credit flow control.
// Optional conflict statistics counter enabled by defining SS_ARB_STATS_EN.
module ss_oport_arbiter
  import pronoc_pkg::*;
#(
  parameter int NR = 3,
  parameter int V  = 4,
  parameter int B  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NR-1:0] req_i,
  input  logic [NR-1:0] hdr_i,
  input  logic [NR-1:0] tail_i,
  input  logic [NR*V-1:0] ovc_i,
  input  logic [V-1:0]  credit_in,
  output logic [NR-1:0] grant_o,
  output logic          flit_wr_o,
  output logic [V-1:0]  ovc_avb_o,
  output logic          locked_o,
  output logic          err_o,
  output logic [15:0]   stat_conflicts_o
);

  localparam int PW = (NR > 1) ? $clog2(NR) : 1;

  ss_arb_state_t state;
  logic [PW-1:0] owner;
  logic [PW-1:0] ptr;
  logic [V-1:0]  lock_vc;
  logic          err_q;

  logic [V-1:0]  ovc_a [NR];
  logic [NR-1:0] elig;
  logic [NR-1:0] gnt;
  logic [PW-1:0] win;
  logic          found;
  logic [V-1:0]  dec_vc;
  logic [V-1:0]  ovf;
  int            idx;

  always_comb begin
    for (int r = 0; r < NR; r++) begin
      ovc_a[r] = ovc_i[r*V +: V];
      elig[r]  = req_i[r] && hdr_i[r] && $onehot(ovc_a[r]) && |(ovc_a[r] & ovc_avb_o);
    end
  end

  always_comb begin
    gnt    = '0;
    win    = '0;
    found  = 1'b0;
    dec_vc = '0;
    idx    = 0;
    if (state == IDLE) begin
      for (int k = 0; k < NR; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NR) idx = idx - NR;
        if (!found && elig[idx]) begin
          found = 1'b1;
          win   = PW'(idx);
        end
      end
      if (found) begin
        gnt[win] = 1'b1;
        dec_vc   = ovc_a[win];
      end
    end else if (req_i[owner] && |(lock_vc & ovc_avb_o)) begin
      gnt[owner] = 1'b1;
      dec_vc     = lock_vc;
    end
    // No grant may escape while reset is held, even though the FSM already sits in IDLE.
    if (!reset) begin
      gnt    = '0;
      dec_vc = '0;
      found  = 1'b0;
    end
  end

  assign grant_o   = gnt;
  assign flit_wr_o = |gnt;
  assign locked_o  = (state == LOCKED);
  assign err_o     = err_q;

  for (genvar v = 0; v < V; v++) begin : g_crd
    ss_ovc_credit_counter #(.B(B)) u_crd (
      .clk   (clk),
      .reset (reset),
      .dec   (dec_vc[v]),
      .inc   (credit_in[v]),
      .avb   (ovc_avb_o[v]),
      .ovf   (ovf[v])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      lock_vc <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          ptr <= (win == PW'(NR - 1)) ? '0 : win + 1'b1;
          if (!tail_i[win]) begin
            state   <= LOCKED;
            owner   <= win;
            lock_vc <= dec_vc;
          end
        end
        LOCKED: if (gnt[owner] && tail_i[owner]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | (|ovf);
  end

`ifdef SS_ARB_STATS_EN
  logic [15:0]   stat_q;
  logic [NR-1:0] owner_oh;
  logic          conflict;

  assign owner_oh = NR'(1) << owner;
  assign conflict = (state == IDLE) ? ($countones(elig) >= 2) : |(req_i & ~owner_oh);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stat_q <= '0;
    else if (conflict && stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
  end

  assign stat_conflicts_o = stat_q;
`else
  assign stat_conflicts_o = '0;
`endif

endmodule

// File: tb/tb_ss_oport_arbiter.sv
// Directed self-checking bench for ss_oport_arbiter (NR=3, V=4, B=4).
module tb_ss_oport_arbiter;

  localparam int NR = 3;
  localparam int V  = 4;
  localparam int B  = 4;
`ifdef SS_ARB_STATS_EN
  localparam logic [15:0] EXP_STAT = 16'd3;
`else
  localparam logic [15:0] EXP_STAT = 16'd0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_i, hdr_i, tail_i;
  logic [NR*V-1:0] ovc_i;
  logic [V-1:0]    credit_in;
  logic [NR-1:0]   grant_o;
  logic            flit_wr_o;
  logic [V-1:0]    ovc_avb_o;
  logic            locked_o;
  logic            err_o;
  logic [15:0]     stat_conflicts_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ss_oport_arbiter #(.NR(NR), .V(V), .B(B)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_i            (req_i),
    .hdr_i            (hdr_i),
    .tail_i           (tail_i),
    .ovc_i            (ovc_i),
    .credit_in        (credit_in),
    .grant_o          (grant_o),
    .flit_wr_o        (flit_wr_o),
    .ovc_avb_o        (ovc_avb_o),
    .locked_o         (locked_o),
    .err_o            (err_o),
    .stat_conflicts_o (stat_conflicts_o)
  );

  task automatic drive(input logic [NR-1:0] rq, input logic [NR-1:0] hd, input logic [NR-1:0] tl,
                       input logic [NR*V-1:0] ov, input logic [V-1:0] cr);
    req_i = rq; hdr_i = hd; tail_i = tl; ovc_i = ov; credit_in = cr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive('0, '0, '0, '0, '0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(3'b111, 3'b111, 3'b111, {4'b0001, 4'b0001, 4'b0001}, 4'b0000);
    repeat (2) @(posedge clk);
    #2;
    tests++; if (grant_o !== 3'b000) begin fails++; $display("FAIL reset_grant got=%b exp=000", grant_o); end
    tests++; if (flit_wr_o !== 1'b0) begin fails++; $display("FAIL reset_flit_wr got=%b exp=0", flit_wr_o); end
    tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL reset_locked got=%b exp=0", locked_o); end
    tests++; if (ovc_avb_o !== 4'b1111) begin fails++; $display("FAIL reset_avb got=%b exp=1111", ovc_avb_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err_o); end
    tests++; if (stat_conflicts_o !== 16'd0) begin fails++; $display("FAIL reset_stat got=%0d exp=0", stat_conflicts_o); end
    drive('0, '0, '0, '0, '0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g [4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    do_reset();
    // Credit returned every cycle keeps VC0 from running dry.
    drive(3'b111, 3'b111, 3'b111, {4'b0001, 4'b0001, 4'b0001}, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (grant_o !== exp_g[i]) begin fails++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, grant_o, exp_g[i]); end
      tests++; if (flit_wr_o !== 1'b1) begin fails++; $display("FAIL rr_flit_wr[%0d] got=%b exp=1", i, flit_wr_o); end
      next_cycle();
    end
    drive('0, '0, '0, '0, '0);
  endtask

  task automatic test_packet_lock();
    do_reset();
    drive(3'b011, 3'b011, 3'b010, {4'b0000, 4'b0100, 4'b0010}, 4'b0000);
    @(negedge clk);
    tests++; if (grant_o !== 3'b001) begin fails++; $display("FAIL lock_hdr_grant got=%b exp=001", grant_o); end
    tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL lock_hdr_locked got=%b exp=0", locked_o); end
    next_cycle();
    drive(3'b011, 3'b010, 3'b010, {4'b0000, 4'b0100, 4'b0010}, 4'b0000);
    @(negedge clk);
    tests++; if (grant_o !== 3'b001) begin fails++; $display("FAIL lock_body_grant got=%b exp=001", grant_o); end
    tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL lock_body_locked got=%b exp=1", locked_o); end
    next_cycle();
    drive(3'b011, 3'b010, 3'b011, {4'b0000, 4'b0100, 4'b0010}, 4'b0000);
    @(negedge clk);
    tests++; if (grant_o !== 3'b001) begin fails++; $display("FAIL lock_tail_grant got=%b exp=001", grant_o); end
    tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL lock_tail_locked got=%b exp=1", locked_o); end
    next_cycle();
    drive(3'b010, 3'b010, 3'b010, {4'b0000, 4'b0100, 4'b0000}, 4'b0000);
    @(negedge clk);
    tests++; if (grant_o !== 3'b010) begin fails++; $display("FAIL lock_next_grant got=%b exp=010", grant_o); end
    tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL lock_next_locked got=%b exp=0", locked_o); end
    next_cycle();
    drive('0, '0, '0, '0, '0);
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    drive(3'b001, 3'b001, 3'b001, {4'b0000, 4'b0000, 4'b0100}, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++; if (grant_o !== 3'b001) begin fails++; $display("FAIL crd_grant[%0d] got=%b exp=001", i, grant_o); end
      next_cycle();
    end
    tests++; if (ovc_avb_o !== 4'b1011) begin fails++; $display("FAIL crd_avb_empty got=%b exp=1011", ovc_avb_o); end
    @(negedge clk);
    tests++; if (grant_o !== 3'b000) begin fails++; $display("FAIL crd_blocked got=%b exp=000", grant_o); end
    next_cycle();
    credit_in = 4'b0100;
    @(negedge clk);
    tests++; if (grant_o !== 3'b000) begin fails++; $display("FAIL crd_return_cycle got=%b exp=000", grant_o); end
    next_cycle();
    credit_in = 4'b0000;
    tests++; if (ovc_avb_o !== 4'b1111) begin fails++; $display("FAIL crd_avb_back got=%b exp=1111", ovc_avb_o); end
    @(negedge clk);
    tests++; if (grant_o !== 3'b001) begin fails++; $display("FAIL crd_regrant got=%b exp=001", grant_o); end
    next_cycle();
    drive('0, '0, '0, '0, '0);
  endtask

  task automatic test_credit_overflow();
    do_reset();
    drive(3'b001, 3'b001, 3'b001, {4'b0000, 4'b0000, 4'b0001}, 4'b0000);
    repeat (2) next_cycle();
    // Count is 2: grant and return in the same cycle must cancel.
    credit_in = 4'b0001;
    @(negedge clk);
    tests++; if (grant_o !== 3'b001) begin fails++; $display("FAIL ovf_both_grant got=%b exp=001", grant_o); end
    next_cycle();
    credit_in = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (grant_o !== 3'b001) begin fails++; $display("FAIL ovf_drain[%0d] got=%b exp=001", i, grant_o); end
      next_cycle();
    end
    @(negedge clk);
    tests++; if (grant_o !== 3'b000) begin fails++; $display("FAIL ovf_drained got=%b exp=000", grant_o); end
    drive('0, '0, '0, '0, 4'b0001);
    repeat (4) next_cycle();
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL ovf_err_early got=%b exp=0", err_o); end
    next_cycle();
    credit_in = 4'b0000;
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL ovf_err_set got=%b exp=1", err_o); end
    repeat (2) next_cycle();
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL ovf_err_sticky got=%b exp=1", err_o); end
    tests++; if (ovc_avb_o !== 4'b1111) begin fails++; $display("FAIL ovf_avb got=%b exp=1111", ovc_avb_o); end
  endtask

  task automatic test_ignore();
    do_reset();
    drive(3'b001, 3'b000, 3'b001, {4'b0000, 4'b0000, 4'b0001}, 4'b0000);
    @(negedge clk);
    tests++; if (grant_o !== 3'b000) begin fails++; $display("FAIL ign_nohdr got=%b exp=000", grant_o); end
    next_cycle();
    drive(3'b010, 3'b010, 3'b010, {4'b0000, 4'b0011, 4'b0000}, 4'b0000);
    @(negedge clk);
    tests++; if (grant_o !== 3'b000) begin fails++; $display("FAIL ign_multihot got=%b exp=000", grant_o); end
    next_cycle();
    drive(3'b100, 3'b100, 3'b100, {4'b0000, 4'b0000, 4'b0000}, 4'b0000);
    @(negedge clk);
    tests++; if (grant_o !== 3'b000) begin fails++; $display("FAIL ign_zero_ovc got=%b exp=000", grant_o); end
    next_cycle();
    drive('0, '0, '0, '0, '0);
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive(3'b001, 3'b001, 3'b000, {4'b0000, 4'b0000, 4'b0001}, 4'b0000);
    next_cycle();
    drive(3'b010, 3'b010, 3'b010, {4'b0000, 4'b0001, 4'b0000}, 4'b0000);
    @(negedge clk);
    tests++; if (grant_o !== 3'b000) begin fails++; $display("FAIL mid_owner_idle got=%b exp=000", grant_o); end
    tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL mid_hold_locked got=%b exp=1", locked_o); end
    next_cycle();
    drive(3'b001, 3'b000, 3'b000, {4'b0000, 4'b0000, 4'b0001}, 4'b0000);
    reset = 1'b0;
    #2;
    tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL mid_rst_locked got=%b exp=0", locked_o); end
    next_cycle();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (grant_o !== 3'b000) begin fails++; $display("FAIL mid_body_grant[%0d] got=%b exp=000", i, grant_o); end
      tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL mid_body_locked[%0d] got=%b exp=0", i, locked_o); end
      next_cycle();
    end
    drive('0, '0, '0, '0, '0);
  endtask

  task automatic test_stats();
    do_reset();
    drive(3'b011, 3'b011, 3'b011, {4'b0000, 4'b0010, 4'b0001}, 4'b0000);
    repeat (3) next_cycle();
    drive('0, '0, '0, '0, '0);
    tests++; if (stat_conflicts_o !== EXP_STAT) begin fails++; $display("FAIL stat_count got=%0d exp=%0d", stat_conflicts_o, EXP_STAT); end
    next_cycle();
    tests++; if (stat_conflicts_o !== EXP_STAT) begin fails++; $display("FAIL stat_hold got=%0d exp=%0d", stat_conflicts_o, EXP_STAT); end
  endtask

  initial begin
    reset = 1'b0;
    drive('0, '0, '0, '0, '0);
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_credit_exhaust();
    test_credit_overflow();
    test_ignore();
    test_reset_mid_packet();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
